// File: rtl/ingress_port_req.sv
// ---------------------------------------------------------------------------
// ingress_port_req
//   Requester side of the switch arbiter handshake, one instance per input
//   port. Incoming flits are buffered in a small FIFO. The destination mask is
//   decoded from each header flit and presented to the arbiter. Each grant
//   forwards exactly one flit onto the crossbar one cycle later.
//
// Optional feature macro: INGRESS_STATS_EN
//   defined   -> saturating 16-bit packet sent / dropped counters
//   undefined -> both counter outputs tied to 0, no counter flops
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   i_in_valid        upstream flit valid
//   o_in_ready        FIFO can accept a flit (registered, = !full)
//   i_in_data         flit payload; [DST_W-1:0] is the dst mask on a header
//   i_in_sop/i_in_eop header / last flit markers
//   o_port_req        request to arbiter (registered, = REQ && FIFO non-empty)
//   o_port_dst        destination mask of the current packet
//   i_grant           arbiter grant for this port
//   o_xbar_*          registered crossbar flit; all zero when not valid
//   o_busy            FSM not idle or FIFO non-empty
//   o_pkt_sent_cnt    packets fully forwarded
//   o_pkt_drop_cnt    packets dropped (zero destination mask)
// ---------------------------------------------------------------------------
module ingress_port_req #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DST_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [DATA_W-1:0] i_in_data,
  input  logic              i_in_sop,
  input  logic              i_in_eop,
  output logic              o_port_req,
  output logic [DST_W-1:0]  o_port_dst,
  input  logic              i_grant,
  output logic              o_xbar_valid,
  output logic [DATA_W-1:0] o_xbar_data,
  output logic              o_xbar_sop,
  output logic              o_xbar_eop,
  output logic              o_busy,
  output logic [15:0]       o_pkt_sent_cnt,
  output logic [15:0]       o_pkt_drop_cnt
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ENT_W = DATA_W + 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  // FIFO storage and control
  logic [ENT_W-1:0]  r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  // FSM and registered outputs
  state_t            r_state;
  logic [DST_W-1:0]  r_port_dst;
  logic              r_port_req;
  logic              r_in_ready;
  logic              r_busy;
  logic              r_xbar_valid;
  logic [DATA_W-1:0] r_xbar_data;
  logic              r_xbar_sop;
  logic              r_xbar_eop;

  // Decode
  logic              w_push;
  logic              w_pop;
  logic              w_fwd;
  logic              w_latch_dst;
  logic              w_empty;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  w_count_nxt;
  logic [ENT_W-1:0]  w_head;
  logic              w_head_sop;
  logic              w_head_eop;
  logic [DATA_W-1:0] w_head_data;
  logic [DST_W-1:0]  w_head_mask;

  assign w_empty     = (r_count == '0);
  assign w_push      = i_in_valid && r_in_ready;
  assign w_head      = r_mem[r_rd_ptr];
  assign w_head_sop  = w_head[ENT_W-1];
  assign w_head_eop  = w_head[ENT_W-2];
  assign w_head_data = w_head[DATA_W-1:0];
  assign w_head_mask = w_head_data[DST_W-1:0];

  // Next-state, pop and forward decision for the head flit
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_fwd       = 1'b0;
    w_latch_dst = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          if (!w_head_sop) begin
            // Framing error: discard stray body flits between packets
            w_pop = 1'b1;
          end else if (w_head_mask != '0) begin
            w_state_nxt = ST_REQ;
            w_latch_dst = 1'b1;
          end else begin
            w_state_nxt = ST_DROP;
          end
        end
      end
      ST_REQ: begin
        // r_port_req already implies a non-empty FIFO
        if (i_grant && r_port_req) begin
          w_pop = 1'b1;
          w_fwd = 1'b1;
          if (w_head_eop) begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      ST_DROP: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          if (w_head_eop) begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

  // FIFO payload write; storage needs no reset
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {i_in_sop, i_in_eop, i_in_data};
    end
  end

  // State, pointers and outputs. Status outputs are registered from the
  // next-cycle state/occupancy, so they equal their combinational definitions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_port_dst   <= '0;
      r_port_req   <= 1'b0;
      r_in_ready   <= 1'b1;
      r_busy       <= 1'b0;
      r_xbar_valid <= 1'b0;
      r_xbar_data  <= '0;
      r_xbar_sop   <= 1'b0;
      r_xbar_eop   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_latch_dst) begin
        r_port_dst <= w_head_mask;
      end
      r_port_req   <= (w_state_nxt == ST_REQ) && (w_count_nxt != '0);
      r_in_ready   <= (w_count_nxt != CNT_W'(DEPTH));
      r_busy       <= (w_state_nxt != ST_IDLE) || (w_count_nxt != '0);
      r_xbar_valid <= w_fwd;
      r_xbar_data  <= w_fwd ? w_head_data : '0;
      r_xbar_sop   <= w_fwd && w_head_sop;
      r_xbar_eop   <= w_fwd && w_head_eop;
    end
  end

  assign o_in_ready   = r_in_ready;
  assign o_port_req   = r_port_req;
  assign o_port_dst   = r_port_dst;
  assign o_busy       = r_busy;
  assign o_xbar_valid = r_xbar_valid;
  assign o_xbar_data  = r_xbar_data;
  assign o_xbar_sop   = r_xbar_sop;
  assign o_xbar_eop   = r_xbar_eop;

`ifdef INGRESS_STATS_EN
  logic [15:0] r_sent_cnt;
  logic [15:0] r_drop_cnt;
  logic        w_drop_entry;

  assign w_drop_entry = (r_state == ST_IDLE) && (w_state_nxt == ST_DROP);

  // Saturating packet statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sent_cnt <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_fwd && w_head_eop && (r_sent_cnt != 16'hFFFF)) begin
        r_sent_cnt <= r_sent_cnt + 16'd1;
      end
      if (w_drop_entry && (r_drop_cnt != 16'hFFFF)) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end
  end

  assign o_pkt_sent_cnt = r_sent_cnt;
  assign o_pkt_drop_cnt = r_drop_cnt;
`else
  assign o_pkt_sent_cnt = 16'd0;
  assign o_pkt_drop_cnt = 16'd0;
`endif

endmodule
